bnn_stream_loader: RTL and testbench

Parametrised serial-to-parallel loader feeding the MNIST BNN datapath: accepts an image bitstream and a weight bitstream over independent valid/ready channels, several bits per beat, and assembles them into flat pixel and three-layer weight registers. It sits between the chip-level input pins/deserialiser and the convolution/dense stages, controlled by the top-level FSM through a start/done pair. Unlike the previous fixed loader, it has the following:
- Configurable sizes and lane counts.
- Back-pressure.
- A pixels-only reload mode that keeps weights across images.

---
 rtl/bnn_stream_loader.sv | 158 +++++++++++++++
 tb/tb_bnn_stream_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_stream_loader.sv
// Serial-to-parallel loader for the MNIST BNN: assembles pixel and weight bitstreams into flat registers.
// Optional trailing even-parity beat per stream when LOADER_PARITY_EN is defined.
module bnn_stream_loader #(
  parameter int PIX_BITS  = 784,
  parameter int PIX_LANES = 1,
  parameter int W1_BITS   = 72,
  parameter int W2_BITS   = 288,
  parameter int W3_BITS   = 1960,
  parameter int W_LANES   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 reload_w,
  input  logic                 p_valid,
  input  logic [PIX_LANES-1:0] p_data,
  output logic                 p_ready,
  input  logic                 w_valid,
  input  logic [W_LANES-1:0]   w_data,
  output logic                 w_ready,
  output logic [PIX_BITS-1:0]  pixels,
  output logic [W1_BITS-1:0]   weights1,
  output logic [W2_BITS-1:0]   weights2,
  output logic [W3_BITS-1:0]   weights3,
  output logic                 busy,
  output logic                 load_done,
  output logic                 parity_err
);
  localparam int W_BITS   = W1_BITS + W2_BITS + W3_BITS;
  localparam int P_DBEATS = (PIX_BITS + PIX_LANES - 1) / PIX_LANES;
  localparam int W_DBEATS = (W_BITS + W_LANES - 1) / W_LANES;
`ifdef LOADER_PARITY_EN
  localparam int PAR_BEATS = 1;
`else
  localparam int PAR_BEATS = 0;
`endif
  localparam int P_BEATS = P_DBEATS + PAR_BEATS;
  localparam int W_BEATS = W_DBEATS + PAR_BEATS;
  localparam int PCW     = $clog2(P_BEATS + 1);
  localparam int WCW     = $clog2(W_BEATS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state;
  logic [PCW-1:0]      p_cnt;
  logic [WCW-1:0]      w_cnt;
  logic                mode_w;
  logic [PIX_BITS-1:0] pix_q, pix_nxt;
  logic [W_BITS-1:0]   w_q, w_nxt;
  logic                p_cmp, w_cmp, p_acc, w_acc, p_fin, w_fin, go;

  assign p_cmp   = (p_cnt == PCW'(P_BEATS));
  assign w_cmp   = !mode_w || (w_cnt == WCW'(W_BEATS));
  assign p_ready = (state == LOAD) && !p_cmp;
  assign w_ready = (state == LOAD) && !w_cmp;
  assign p_acc   = p_valid && p_ready;
  assign w_acc   = w_valid && w_ready;
  // stream is finished after this edge if already complete or its last beat lands now
  assign p_fin   = p_cmp || (p_acc && p_cnt == PCW'(P_BEATS - 1));
  assign w_fin   = w_cmp || (w_acc && w_cnt == WCW'(W_BEATS - 1));
  assign go      = start && (state != LOAD);

  // each register bit has a fixed (beat, lane) home, so writes are constant-indexed
  for (genvar i = 0; i < PIX_BITS; i++) begin : g_pix
    assign pix_nxt[i] = (p_acc && p_cnt == PCW'(i / PIX_LANES)) ? p_data[i % PIX_LANES] : pix_q[i];
  end
  for (genvar i = 0; i < W_BITS; i++) begin : g_w
    assign w_nxt[i] = (w_acc && w_cnt == WCW'(i / W_LANES)) ? w_data[i % W_LANES] : w_q[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      p_cnt     <= '0;
      w_cnt     <= '0;
      mode_w    <= 1'b0;
      pix_q     <= '0;
      w_q       <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state     <= LOAD;
          p_cnt     <= '0;
          w_cnt     <= '0;
          mode_w    <= reload_w;
          busy      <= 1'b1;
          load_done <= 1'b0;
        end
        LOAD: begin
          if (p_acc) p_cnt <= p_cnt + 1'b1;
          if (w_acc) w_cnt <= w_cnt + 1'b1;
          pix_q <= pix_nxt;
          w_q   <= w_nxt;
          if (p_fin && w_fin) begin
            state     <= DONE;
            busy      <= 1'b0;
            load_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_PARITY_EN
  localparam int P_LAST = PIX_BITS - (P_DBEATS - 1) * PIX_LANES;
  localparam int W_LAST = W_BITS - (W_DBEATS - 1) * W_LANES;

  logic [PIX_LANES-1:0] p_mask;
  logic [W_LANES-1:0]   w_mask;
  logic                 p_par, w_par, perr_q, p_pbeat, w_pbeat;

  // discarded lanes of the final data beat stay out of the parity sum
  for (genvar j = 0; j < PIX_LANES; j++) begin : g_pm
    if (j < P_LAST) begin : g_on
      assign p_mask[j] = 1'b1;
    end else begin : g_cut
      assign p_mask[j] = (p_cnt != PCW'(P_DBEATS - 1));
    end
  end
  for (genvar j = 0; j < W_LANES; j++) begin : g_wm
    if (j < W_LAST) begin : g_on
      assign w_mask[j] = 1'b1;
    end else begin : g_cut
      assign w_mask[j] = (w_cnt != WCW'(W_DBEATS - 1));
    end
  end

  assign p_pbeat = p_acc && (p_cnt == PCW'(P_DBEATS));
  assign w_pbeat = w_acc && (w_cnt == WCW'(W_DBEATS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_par  <= 1'b0;
      w_par  <= 1'b0;
      perr_q <= 1'b0;
    end else if (go) begin
      p_par  <= 1'b0;
      w_par  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (p_acc && !p_pbeat) p_par <= p_par ^ (^(p_data & p_mask));
      if (w_acc && !w_pbeat) w_par <= w_par ^ (^(w_data & w_mask));
      if ((p_pbeat && p_data[0] != p_par) || (w_pbeat && w_data[0] != w_par)) perr_q <= 1'b1;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign pixels   = pix_q;
  assign weights1 = w_q[W1_BITS-1:0];
  assign weights2 = w_q[W1_BITS+W2_BITS-1:W1_BITS];
  assign weights3 = w_q[W_BITS-1:W1_BITS+W2_BITS];
endmodule

// File: tb/tb_bnn_stream_loader.sv
// Directed/randomized bench for bnn_stream_loader with 8 pixel lanes and 3 weight lanes.
module tb_bnn_stream_loader;
  localparam int PIX_BITS = 784, PIX_LANES = 8;
  localparam int W1_BITS = 72, W2_BITS = 288, W3_BITS = 1960, W_LANES = 3;
  localparam int W_BITS   = W1_BITS + W2_BITS + W3_BITS;
  localparam int P_DBEATS = 98;
  localparam int W_DBEATS = 774;
`ifdef LOADER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int P_BEATS = P_DBEATS + PAR;
  localparam int W_BEATS = W_DBEATS + PAR;

  logic clk = 1'b0;
  logic reset, start, reload_w, p_valid, w_valid;
  logic [PIX_LANES-1:0] p_data;
  logic [W_LANES-1:0]   w_data;
  logic p_ready, w_ready, busy, load_done, parity_err;
  logic [PIX_BITS-1:0] pixels;
  logic [W1_BITS-1:0]  weights1;
  logic [W2_BITS-1:0]  weights2;
  logic [W3_BITS-1:0]  weights3;

  bnn_stream_loader #(
    .PIX_BITS(PIX_BITS), .PIX_LANES(PIX_LANES), .W1_BITS(W1_BITS),
    .W2_BITS(W2_BITS), .W3_BITS(W3_BITS), .W_LANES(W_LANES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .reload_w(reload_w),
    .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .pixels(pixels), .weights1(weights1), .weights2(weights2), .weights3(weights3),
    .busy(busy), .load_done(load_done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0, to_p = 0, to_w = 0, cyc = 0;
  bit wr_seen, done_early;
  logic [PIX_BITS-1:0] img;
  logic [W_BITS-1:0]   wts;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h (low 64 bits, %0d bits differ)",
             tag, obs[63:0], exp[63:0], $countones(obs ^ exp));
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic new_img();
    for (int i = 0; i < PIX_BITS; i++) img[i] = 1'($urandom);
  endtask

  task automatic new_wts();
    for (int i = 0; i < W_BITS; i++) wts[i] = 1'($urandom);
  endtask

  // beat k lane j carries bit k*LANES+j; padding lanes driven 1; optional parity beat last
  task automatic drive_pix(input int nb, input bit gaps);
    logic [PIX_LANES-1:0] b;
    bit acc;
    int t;
    for (int k = 0; k < nb; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin p_valid = 1'b0; step(); end
      for (int j = 0; j < PIX_LANES; j++) begin
        if (k >= P_DBEATS) b[j] = (j == 0) ? ^img : 1'($urandom);
        else b[j] = (k * PIX_LANES + j < PIX_BITS) ? img[k * PIX_LANES + j] : 1'b1;
      end
      p_valid = 1'b1;
      p_data  = b;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = p_ready;
        wr_seen |= w_ready;
        done_early |= load_done;
        step();
        t++;
      end
      if (!acc) begin to_p++; p_valid = 1'b0; return; end
    end
    p_valid = 1'b0;
  endtask

  task automatic drive_w(input int nb, input bit gaps, input bit badpar);
    logic [W_LANES-1:0] b;
    bit acc;
    int t;
    for (int k = 0; k < nb; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin w_valid = 1'b0; step(); end
      for (int j = 0; j < W_LANES; j++) begin
        if (k >= W_DBEATS) b[j] = (j == 0) ? (^wts ^ badpar) : 1'($urandom);
        else b[j] = (k * W_LANES + j < W_BITS) ? wts[k * W_LANES + j] : 1'b1;
      end
      w_valid = 1'b1;
      w_data  = b;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = w_ready;
        done_early |= load_done;
        step();
        t++;
      end
      if (!acc) begin to_w++; w_valid = 1'b0; return; end
    end
    w_valid = 1'b0;
  endtask

  task automatic do_start(input logic r);
    start = 1'b1;
    reload_w = r;
    step();
    start = 1'b0;
  endtask

  task automatic pulses();
    repeat (5) begin
      repeat ($urandom_range(1, 5)) step();
      start = 1'b1;
      reload_w = 1'($urandom);
      step();
      start = 1'b0;
    end
  endtask

  task automatic check_data(input string tag);
    chk({tag, ".pixels"}, 2048'(pixels), 2048'(img));
    chk({tag, ".weights1"}, 2048'(weights1), 2048'(wts[W1_BITS-1:0]));
    chk({tag, ".weights2"}, 2048'(weights2), 2048'(wts[W1_BITS+W2_BITS-1:W1_BITS]));
    chk({tag, ".weights3"}, 2048'(weights3), 2048'(wts[W_BITS-1:W1_BITS+W2_BITS]));
  endtask

  // one complete load; lat_exp < 0 skips the start-to-done cycle count
  task automatic full_load(input string tag, input logic r, input bit gaps, input bit badw,
                           input bit pulse, input int lat_exp, input logic perr_exp);
    int c0;
    done_early = 1'b0;
    wr_seen = 1'b0;
    do_start(r);
    c0 = cyc;
    chk1({tag, ".busy_after_start"}, busy, 1'b1);
    chk1({tag, ".done_after_start"}, load_done, 1'b0);
    chk1({tag, ".perr_after_start"}, parity_err, 1'b0);
    chk1({tag, ".p_ready_after_start"}, p_ready, 1'b1);
    chk1({tag, ".w_ready_after_start"}, w_ready, r);
    fork
      drive_pix(P_BEATS, gaps);
      if (r) drive_w(W_BEATS, gaps, badw);
      if (pulse) pulses();
    join
    if (lat_exp >= 0) chk({tag, ".latency"}, 2048'(cyc - c0), 2048'(lat_exp));
    chk1({tag, ".load_done"}, load_done, 1'b1);
    chk1({tag, ".busy_end"}, busy, 1'b0);
    chk1({tag, ".done_early"}, done_early, 1'b0);
    chk1({tag, ".p_ready_end"}, p_ready, 1'b0);
    chk1({tag, ".w_ready_end"}, w_ready, 1'b0);
    chk1({tag, ".parity_err"}, parity_err, perr_exp);
    if (!r) chk1({tag, ".w_ready_seen"}, wr_seen, 1'b0);
    check_data(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".pixels"}, 2048'(pixels), 2048'(0));
    chk({tag, ".weights"}, 2048'({weights3, weights2, weights1}), 2048'(0));
    chk1({tag, ".busy"}, busy, 1'b0);
    chk1({tag, ".load_done"}, load_done, 1'b0);
    chk1({tag, ".parity_err"}, parity_err, 1'b0);
    chk1({tag, ".p_ready"}, p_ready, 1'b0);
    chk1({tag, ".w_ready"}, w_ready, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; reload_w = 1'b0;
    p_valid = 1'b0; w_valid = 1'b0; p_data = '0; w_data = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_zero("reset");

    // random valid gaps on both streams
    new_img(); new_wts();
    full_load("loadA", 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);

    // valid held; slower stream sets latency; start pulses in LOAD are ignored
    new_img(); new_wts();
    full_load("loadB", 1'b1, 1'b0, 1'b0, 1'b1, W_BEATS, 1'b0);

    // pixels-only reload keeps weights
    new_img();
    full_load("loadC", 1'b0, 1'b0, 1'b0, 1'b0, P_BEATS, 1'b0);

    // reset partway through the weight stream
    new_img(); new_wts();
    do_start(1'b1);
    fork
      drive_pix(P_BEATS, 1'b0);
      drive_w(400, 1'b0, 1'b0);
    join
    chk1("midload.busy", busy, 1'b1);
    reset = 1'b1;
    step();
    check_zero("midreset");
    reset = 1'b0;
    step();
    new_img(); new_wts();
    full_load("loadD", 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);

`ifdef LOADER_PARITY_EN
    new_img(); new_wts();
    full_load("badpar", 1'b1, 1'b0, 1'b1, 1'b0, W_BEATS, 1'b1);
    new_img(); new_wts();
    full_load("goodpar", 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
`endif

    chk("timeouts", 2048'(to_p + to_w), 2048'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
